// File: rtl/m_cpu_seq_if.sv
// Sequencer bus: program fetch, datapath dispatch, interrupt/sleep control and status.
// master = sequencer side, slave = memory/datapath/environment side.
interface m_cpu_seq_if #(
  parameter int AW   = 10,
  parameter int DW   = 16,
  parameter int NIRQ = 4
);
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic          run;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_data;
  logic          instr_valid;
  logic          exec_valid;
  logic [3:0]    exec_op;
  logic [DW-5:0] exec_arg;
  logic          exec_ready;
  logic          zero_flag;
  logic          sleep_req;
  logic          wake_req;
  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] imask;
  logic          irq_ack;
  logic [IW-1:0] irq_id;
  logic [AW-1:0] pc;
  logic [2:0]    state;
  logic          fault;

  modport master (
    input  run, instr_data, instr_valid, exec_ready, zero_flag,
           sleep_req, wake_req, irq, imask,
    output instr_req, instr_addr, exec_valid, exec_op, exec_arg,
           irq_ack, irq_id, pc, state, fault
  );

  modport slave (
    output run, instr_data, instr_valid, exec_ready, zero_flag,
           sleep_req, wake_req, irq, imask,
    input  instr_req, instr_addr, exec_valid, exec_op, exec_arg,
           irq_ack, irq_id, pc, state, fault
  );
endinterface

// File: rtl/m_cpu_seq.sv
// Instruction sequencer: fetch/decode/exec FSM with return stack, vectored maskable
// interrupts, sleep/wake and sticky fault. All bus outputs are registered.
module m_cpu_seq #(
  parameter int AW          = 10,
  parameter int DW          = 16,
  parameter int STACK_DEPTH = 8,
  parameter int NIRQ        = 4,
  parameter int RESET_VEC   = 0,
  parameter int IRQ_BASE    = 'h3F0
) (
  input  logic         clk,
  input  logic         reset,
  m_cpu_seq_if.master  bus
);
  localparam int IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam int SIW = $clog2(STACK_DEPTH);
  localparam int SPW = SIW + 1;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_BEQ    = 4'd5;
  localparam logic [3:0] OP_RETURN = 4'd6;
  localparam logic [3:0] OP_RETI   = 4'd7;
  localparam logic [3:0] OP_CALL   = 4'd8;
  localparam logic [3:0] OP_SLEEP  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAITX  = 3'd4,
    S_SLEEP  = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [DW-1:0]   ir_q;
  logic [SPW-1:0]  sp_q;
  logic            ie_q;
  logic            boot_q;
  logic            instr_req_q;
  logic            exec_valid_q;
  logic [3:0]      exec_op_q;
  logic [DW-5:0]   exec_arg_q;
  logic            irq_ack_q;
  logic [IW-1:0]   irq_id_q;
  logic            fault_q;
  logic [AW-1:0]   stack_q [STACK_DEPTH];

  logic [3:0]      op;
  logic [AW-1:0]   operand;
  logic [AW-1:0]   pc_inc;
  logic [NIRQ-1:0] irq_pend;
  logic            irq_any;
  logic            is_data_op;

  assign op         = ir_q[DW-1:DW-4];
  assign operand    = ir_q[AW-1:0];
  assign pc_inc     = pc_q + AW'(1);
  assign irq_pend   = bus.irq & bus.imask;
  assign irq_any    = |irq_pend;
  assign is_data_op = (op >= OP_LOAD) && (op <= OP_ADD);

  logic [AW-1:0]   seq_pc_d;
  logic            do_pop_d;
  logic            do_push_d;
  logic            go_sleep_d;
  logic            boundary_d;
  logic            stk_fault_d;
  logic [SPW-1:0]  sp_after_d;
  logic            take_irq_d;
  logic [IW-1:0]   irq_idx_d;
  logic [AW-1:0]   irq_vec_d;

  // Boundary decision: next sequential pc, stack effect, then fault > irq > sleep > fetch.
  always_comb begin
    seq_pc_d   = pc_inc;
    do_pop_d   = 1'b0;
    do_push_d  = 1'b0;
    go_sleep_d = bus.sleep_req;
    if (state_q == S_EXEC) begin
      case (op)
        OP_BRANCH: seq_pc_d = operand;
        OP_BEQ:    if (bus.zero_flag) seq_pc_d = operand;
        OP_RETURN,
        OP_RETI: begin
          do_pop_d = 1'b1;
          seq_pc_d = stack_q[SIW'(sp_q - SPW'(1))];
        end
        OP_CALL: begin
          do_push_d = 1'b1;
          seq_pc_d  = operand;
        end
        OP_SLEEP:  go_sleep_d = 1'b1;
        default:   seq_pc_d = pc_inc;
      endcase
    end

    boundary_d  = ((state_q == S_EXEC) && !is_data_op) ||
                  ((state_q == S_WAITX) && bus.exec_ready);
    stk_fault_d = (do_pop_d && (sp_q == '0)) ||
                  (do_push_d && (sp_q == SPW'(STACK_DEPTH)));
    sp_after_d  = sp_q + SPW'(do_push_d) - SPW'(do_pop_d);
    take_irq_d  = ie_q && irq_any && (sp_after_d < SPW'(STACK_DEPTH));

    irq_idx_d = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx_d = IW'(i);
    end
    irq_vec_d = AW'(IRQ_BASE) + AW'(irq_idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= AW'(RESET_VEC);
      ir_q         <= '0;
      sp_q         <= '0;
      ie_q         <= 1'b0;
      boot_q       <= 1'b1;
      instr_req_q  <= 1'b0;
      exec_valid_q <= 1'b0;
      exec_op_q    <= '0;
      exec_arg_q   <= '0;
      irq_ack_q    <= 1'b0;
      irq_id_q     <= '0;
      fault_q      <= 1'b0;
    end else begin
      irq_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            state_q     <= S_FETCH;
            instr_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.instr_valid) begin
            ir_q        <= bus.instr_data;
            instr_req_q <= 1'b0;
            state_q     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op > OP_SLEEP) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_data_op) begin
            state_q      <= S_WAITX;
            exec_valid_q <= 1'b1;
            exec_op_q    <= op;
            exec_arg_q   <= ir_q[DW-5:0];
          end
        end
        S_WAITX: begin
          if (bus.exec_ready) exec_valid_q <= 1'b0;
        end
        S_SLEEP: begin
          if (bus.wake_req || irq_any) begin
            state_q     <= S_FETCH;
            instr_req_q <= 1'b1;
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_FAULT;
      endcase

      if (boundary_d) begin
        if (stk_fault_d) begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
        end else begin
          sp_q <= sp_after_d;
          if (boot_q) begin
            boot_q <= 1'b0;
            ie_q   <= 1'b1;
          end
          if ((state_q == S_EXEC) && (op == OP_RETI)) ie_q <= 1'b1;
          if (take_irq_d) begin
            sp_q        <= sp_after_d + SPW'(1);
            pc_q        <= irq_vec_d;
            ie_q        <= 1'b0;
            irq_ack_q   <= 1'b1;
            irq_id_q    <= irq_idx_d;
            state_q     <= S_FETCH;
            instr_req_q <= 1'b1;
          end else begin
            pc_q <= seq_pc_d;
            if (go_sleep_d) begin
              state_q <= S_SLEEP;
            end else begin
              state_q     <= S_FETCH;
              instr_req_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Return stack storage needs no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (boundary_d && !stk_fault_d) begin
      if (do_push_d)  stack_q[SIW'(sp_q)]       <= pc_inc;
      if (take_irq_d) stack_q[SIW'(sp_after_d)] <= seq_pc_d;
    end
  end

  assign bus.instr_req  = instr_req_q;
  assign bus.instr_addr = pc_q;
  assign bus.exec_valid = exec_valid_q;
  assign bus.exec_op    = exec_op_q;
  assign bus.exec_arg   = exec_arg_q;
  assign bus.irq_ack    = irq_ack_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.pc         = pc_q;
  assign bus.state      = state_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_m_cpu_seq.sv
// Directed bench for m_cpu_seq: expected fetches/dispatches/irq entries are queued by the
// stimulus and popped by an independent negedge monitor.
module tb_m_cpu_seq;
  logic clk;
  logic reset;

  m_cpu_seq_if #(.AW(10), .DW(16), .NIRQ(4)) bus ();

  m_cpu_seq #(
    .AW(10), .DW(16), .STACK_DEPTH(8), .NIRQ(4), .RESET_VEC(0), .IRQ_BASE('h3F0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  assign bus.instr_valid = bus.instr_req;
  assign bus.instr_data  = mem[bus.instr_addr];

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  exp_fetch  [$];
  logic [15:0] exp_exec   [$];
  logic [1:0]  exp_ack_id [$];
  logic [9:0]  exp_ack_pc [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

  // Monitor: every handshake the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.instr_req && bus.instr_valid) begin
        if (exp_fetch.size() == 0) check("fetch_unexpected", {22'd0, bus.instr_addr}, 32'hFFFF_FFFF);
        else check("fetch_addr", {22'd0, bus.instr_addr}, {22'd0, exp_fetch.pop_front()});
      end
      if (bus.exec_valid && bus.exec_ready) begin
        if (exp_exec.size() == 0) check("exec_unexpected", {16'd0, bus.exec_op, bus.exec_arg}, 32'hFFFF_FFFF);
        else check("exec_dispatch", {16'd0, bus.exec_op, bus.exec_arg}, {16'd0, exp_exec.pop_front()});
      end
      if (bus.irq_ack) begin
        if (exp_ack_id.size() == 0) check("ack_unexpected", {30'd0, bus.irq_id}, 32'hFFFF_FFFF);
        else begin
          check("irq_id", {30'd0, bus.irq_id}, {30'd0, exp_ack_id.pop_front()});
          check("irq_vec_pc", {22'd0, bus.pc}, {22'd0, exp_ack_pc.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_outputs);
    reset = 1'b0;
    bus.run = 1'b0; bus.exec_ready = 1'b1; bus.zero_flag = 1'b0;
    bus.sleep_req = 1'b0; bus.wake_req = 1'b0; bus.irq = '0; bus.imask = '0;
    exp_fetch.delete(); exp_exec.delete(); exp_ack_id.delete(); exp_ack_pc.delete();
    foreach (mem[i]) mem[i] = 16'h0000;
    tick(); tick();
    if (check_outputs) begin
      check("rst_state", {29'd0, bus.state}, 32'd0);
      check("rst_pc", {22'd0, bus.pc}, 32'd0);
      check("rst_outs", {27'd0, bus.instr_req, bus.exec_valid, bus.irq_ack, bus.fault, bus.irq_id != 0}, 32'd0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string nm);
    int n = 0;
    while (bus.state !== s && n < bound) begin
      tick();
      n++;
    end
    check(nm, {29'd0, bus.state}, {29'd0, s});
  endtask

  task automatic wait_exec_valid(input string nm);
    int n = 0;
    while (bus.exec_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(nm, {31'd0, bus.exec_valid}, 32'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;

    // Straight-line fetch, branch and first-instruction timing.
    do_reset(1'b1);
    mem[0] = ins(4'd0, 12'h000);
    mem[1] = ins(4'd4, 12'h005);
    mem[5] = ins(4'd9, 12'h000);
    exp_fetch = '{10'h000, 10'h001, 10'h005};
    bus.run = 1'b1;
    tick(); tick(); tick();
    check("t1_exec_state", {29'd0, bus.state}, 32'd3);
    check("t1_exec_pc", {22'd0, bus.pc}, 32'd0);
    tick();
    check("t1_nop_retired_pc", {22'd0, bus.pc}, 32'd1);
    wait_state(3'd5, 100, "t1_sleep");
    check("t1_end_pc", {22'd0, bus.pc}, 32'd6);
    check("t1_queue", exp_fetch.size(), 32'd0);

    // CALL/RETURN round trip, then taken BEQ.
    do_reset(1'b0);
    mem[3]     = ins(4'd8, 12'h020);
    mem[12'h20] = ins(4'd6, 12'h000);
    mem[4]     = ins(4'd5, 12'h030);
    mem[12'h30] = ins(4'd9, 12'h000);
    exp_fetch = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h020, 10'h004, 10'h030};
    bus.zero_flag = 1'b1;
    bus.run = 1'b1;
    wait_state(3'd5, 200, "t2_sleep");
    check("t2_end_pc", {22'd0, bus.pc}, 32'h31);
    check("t2_sp", {28'd0, dut.sp_q}, 32'd0);
    check("t2_queue", exp_fetch.size(), 32'd0);

    // Masked vectored interrupt during NOP at 7, RETI back to 8.
    do_reset(1'b0);
    mem[8]       = ins(4'd9, 12'h000);
    mem[12'h3F2] = ins(4'd7, 12'h000);
    exp_fetch = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
                  10'h006, 10'h007, 10'h3F2, 10'h008};
    exp_ack_id.push_back(2'd2);
    exp_ack_pc.push_back(10'h3F2);
    bus.run = 1'b1;
    cnt = 0;
    while (!(bus.instr_req && bus.pc == 10'h007) && cnt < 100) begin tick(); cnt++; end
    bus.irq = 4'b0110; bus.imask = 4'b0100;
    cnt = 0;
    while (bus.irq_ack !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    check("t3_ack_seen", {31'd0, bus.irq_ack}, 32'd1);
    bus.irq = 4'b0000;
    wait_state(3'd5, 100, "t3_sleep");
    check("t3_end_pc", {22'd0, bus.pc}, 32'd9);
    check("t3_queue", exp_fetch.size() + exp_ack_id.size(), 32'd0);

    // Nine nested CALLs overflow an eight-entry stack.
    do_reset(1'b0);
    for (int k = 0; k < 9; k++) begin
      mem[k * 16] = ins(4'd8, 12'((k + 1) * 16));
      exp_fetch.push_back(10'(k * 16));
    end
    bus.run = 1'b1;
    wait_state(3'd6, 200, "t4_fault_state");
    check("t4_fault", {31'd0, bus.fault}, 32'd1);
    check("t4_pc", {22'd0, bus.pc}, 32'h80);
    check("t4_sp", {28'd0, dut.sp_q}, 32'd8);
    tick(); tick();
    check("t4_no_req", {31'd0, bus.instr_req}, 32'd0);
    check("t4_queue", exp_fetch.size(), 32'd0);

    // ADD held off by exec_ready for five cycles.
    do_reset(1'b0);
    mem[0] = ins(4'd3, 12'h123);
    mem[1] = ins(4'd9, 12'h000);
    exp_fetch = '{10'h000, 10'h001};
    exp_exec.push_back(16'h3123);
    bus.exec_ready = 1'b0;
    bus.run = 1'b1;
    wait_exec_valid("t5_valid_rise");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_valid_held", {31'd0, bus.exec_valid}, 32'd1);
    end
    bus.exec_ready = 1'b1;
    tick();
    check("t5_valid_drop", {31'd0, bus.exec_valid}, 32'd0);
    wait_state(3'd5, 100, "t5_sleep");
    check("t5_end_pc", {22'd0, bus.pc}, 32'd2);
    check("t5_queue", exp_fetch.size() + exp_exec.size(), 32'd0);

    // SLEEP, ten quiet cycles, wake.
    do_reset(1'b0);
    mem[0] = ins(4'd9, 12'h000);
    mem[2] = ins(4'd9, 12'h000);
    exp_fetch = '{10'h000};
    bus.run = 1'b1;
    wait_state(3'd5, 100, "t6_sleep1");
    check("t6_sleep_pc", {22'd0, bus.pc}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.instr_req) cnt++;
    end
    check("t6_req_while_asleep", cnt, 32'd0);
    exp_fetch.push_back(10'h001);
    exp_fetch.push_back(10'h002);
    bus.wake_req = 1'b1;
    tick();
    bus.wake_req = 1'b0;
    wait_state(3'd5, 100, "t6_sleep2");
    check("t6_end_pc", {22'd0, bus.pc}, 32'd3);
    check("t6_queue", exp_fetch.size(), 32'd0);

    // Illegal opcode faults in DECODE.
    do_reset(1'b0);
    mem[0] = 16'hA000;
    exp_fetch = '{10'h000};
    bus.run = 1'b1;
    wait_state(3'd6, 50, "t7_fault_state");
    check("t7_fault", {31'd0, bus.fault}, 32'd1);
    check("t7_pc", {22'd0, bus.pc}, 32'd0);

    // Asynchronous reset in the middle of WAITX.
    do_reset(1'b0);
    mem[0] = ins(4'd3, 12'h055);
    exp_fetch = '{10'h000};
    bus.exec_ready = 1'b0;
    bus.run = 1'b1;
    wait_exec_valid("t8_in_waitx");
    check("t8_state_waitx", {29'd0, bus.state}, 32'd4);
    reset = 1'b0;
    #1;
    check("t8_rst_state", {29'd0, bus.state}, 32'd0);
    check("t8_rst_pc", {22'd0, bus.pc}, 32'd0);
    check("t8_rst_exec_valid", {31'd0, bus.exec_valid}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
